// File: rtl/reduce_fork_stage_pkg.sv
// Shared types for the reduce/fork stage: queued entry layout and default sizing.
package reduce_fork_pkg;

    localparam int unsigned WIDTH           = 4;
    localparam int unsigned DEFAULT_DEPTH   = 2;
    localparam int unsigned DEFAULT_NUM_OUT = 3;

    typedef struct packed {
        logic             orr;
        logic             andr;
        logic [WIDTH-1:0] in2;
    } rf_entry_t;

    // Reductions are folded in here so the queue never stores the raw operand.
    function automatic rf_entry_t make_entry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        rf_entry_t e;
        e.orr  = |a;
        e.andr = &a;
        e.in2  = b;
        return e;
    endfunction

endpackage

// File: rtl/reduce_fork_stage_if.sv
// Producer-side input handshake plus the NUM_OUT-lane fork outputs of the stage.
interface reduce_fork_if #(
    parameter int unsigned WIDTH   = reduce_fork_pkg::WIDTH,
    parameter int unsigned NUM_OUT = reduce_fork_pkg::DEFAULT_NUM_OUT,
    parameter int unsigned DEPTH   = reduce_fork_pkg::DEFAULT_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               handshake_valid;
    logic               handshake_ready;
    logic [NUM_OUT-1:0] handshake_arr_valid;
    logic [NUM_OUT-1:0] handshake_arr_ready;
    logic               out;
    logic               mon_temp1;
    logic               mon_temp2;
    logic [WIDTH-1:0]   out_in2;
    logic [CW-1:0]      count;

    modport master (
        output in1, in2, handshake_valid, handshake_arr_ready,
        input  handshake_ready, handshake_arr_valid, out, mon_temp1, mon_temp2, out_in2, count
    );

    modport slave (
        input  in1, in2, handshake_valid, handshake_arr_ready,
        output handshake_ready, handshake_arr_valid, out, mon_temp1, mon_temp2, out_in2, count
    );

endinterface

// File: rtl/reduce_fork_stage_fork_tracker.sv
// Tracks which fork lanes have taken the current head and signals when all have.
module fork_tracker #(
    parameter int unsigned NUM_OUT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               active_next,
    input  logic [NUM_OUT-1:0] lane_ready,
    output logic [NUM_OUT-1:0] lane_valid,
    output logic               all_taken_c
);

    logic [NUM_OUT-1:0] done_q;
    logic [NUM_OUT-1:0] done_next;
    logic [NUM_OUT-1:0] lane_fire;

    always_comb begin
        lane_fire   = lane_valid & lane_ready;
        all_taken_c = active && (&(done_q | lane_fire));
        done_next   = all_taken_c ? '0 : (done_q | lane_fire);
    end

    // Lane valids are registered as the decode of the next occupancy/done state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= '0;
            lane_valid <= '0;
        end else begin
            done_q     <= done_next;
            lane_valid <= active_next ? ~done_next : '0;
        end
    end

endmodule

// File: rtl/reduce_fork_stage.sv
// Queues reduced (in1,in2) beats and broadcasts each head to NUM_OUT consumers.
module reduce_fork_stage #(
    parameter int unsigned WIDTH   = reduce_fork_pkg::WIDTH,
    parameter int unsigned NUM_OUT = reduce_fork_pkg::DEFAULT_NUM_OUT,
    parameter int unsigned DEPTH   = reduce_fork_pkg::DEFAULT_DEPTH
) (
    input logic          CLK,
    input logic          ASYNCRESET,
    reduce_fork_if.slave bus
);
    import reduce_fork_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rf_entry_t     mem [DEPTH];
    rf_entry_t     new_entry;
    rf_entry_t     head_q;
    rf_entry_t     head_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          ready_q;
    logic          out_q;
    logic          in_fire;
    logic          pop;
    logic          active;
    logic          active_next;

    fork_tracker #(.NUM_OUT(NUM_OUT)) u_tracker (
        .clk         (CLK),
        .rst         (ASYNCRESET),
        .active      (active),
        .active_next (active_next),
        .lane_ready  (bus.handshake_arr_ready),
        .lane_valid  (bus.handshake_arr_valid),
        .all_taken_c (pop)
    );

    // Head register is reloaded only when the presented beat changes, so it
    // holds the last popped values while the queue is empty.
    always_comb begin
        in_fire    = bus.handshake_valid && ready_q;
        new_entry  = make_entry(bus.in1, bus.in2);
        active     = (count_q != '0);
        count_next = count_q;
        if (in_fire && !pop) begin
            count_next = count_q + CW'(1);
        end else if (!in_fire && pop) begin
            count_next = count_q - CW'(1);
        end
        active_next = (count_next != '0);
        head_next   = head_q;
        if (pop) begin
            if (count_q > CW'(1)) begin
                head_next = mem[PW'(rd_ptr + PW'(1))];
            end else if (in_fire) begin
                head_next = new_entry;
            end
        end else if (!active && in_fire) begin
            head_next = new_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (in_fire) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            if (in_fire) begin
                wr_ptr <= PW'(wr_ptr + PW'(1));
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            count_q <= count_next;
            head_q  <= head_next;
            out_q   <= head_next.orr && head_next.andr;
            ready_q <= (count_next < CW'(DEPTH));
        end
    end

    assign bus.handshake_ready = ready_q;
    assign bus.out             = out_q;
    assign bus.mon_temp1       = head_q.orr;
    assign bus.mon_temp2       = head_q.andr;
    assign bus.out_in2         = head_q.in2;
    assign bus.count           = count_q;

    count_bound: assert property (@(posedge CLK) disable iff (ASYNCRESET) count_q <= CW'(DEPTH));

endmodule
